// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection,
// bubble insertion, flush and a saturating bubble counter.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_RegWrite,
  input  logic [1:0]        id_ALUOp,
  input  logic              id_RegDst,
  input  logic              id_ALUSrc,
  input  logic              id_MemWrite,
  input  logic              id_MemRead,
  input  logic              id_MemtoReg,
  input  logic [DATA_W-1:0] id_ReadData1,
  input  logic [DATA_W-1:0] id_ReadData2,
  input  logic [15:0]       id_imm16,
  input  logic [5:0]        id_funct,
  input  logic [4:0]        id_Rs,
  input  logic [4:0]        id_Rt,
  input  logic [4:0]        id_Rd,
  input  logic              flush,
  output logic              ex_RegWrite,
  output logic [1:0]        ex_ALUOp,
  output logic              ex_RegDst,
  output logic              ex_ALUSrc,
  output logic              ex_MemWrite,
  output logic              ex_MemRead,
  output logic              ex_MemtoReg,
  output logic [DATA_W-1:0] ex_ReadData1,
  output logic [DATA_W-1:0] ex_ReadData2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [5:0]        ex_funct,
  output logic [4:0]        ex_Rs,
  output logic [4:0]        ex_Rt,
  output logic [4:0]        ex_Rd,
  output logic              ex_valid,
  output logic              stall_if_id,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic uses_rt;
  logic load_use;
  logic take;
  logic cnt_inc;

  always_comb begin
    uses_rt  = !id_ALUSrc | id_MemWrite;
    load_use = ex_valid & ex_MemRead & id_valid
             & (ex_Rt != 5'd0)
             & ((ex_Rt == id_Rs)
             | (uses_rt & (ex_Rt == id_Rt)));
    stall_if_id = !rst & !flush & load_use;
    take    = id_valid & !flush & !load_use;
    cnt_inc = !flush & load_use & (bubble_cnt != '1);
  end

  // Controls are gated so a bubble or an empty slot carries no side effects.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_RegWrite  <= 1'b0;
      ex_ALUOp     <= 2'b00;
      ex_RegDst    <= 1'b0;
      ex_ALUSrc    <= 1'b0;
      ex_MemWrite  <= 1'b0;
      ex_MemRead   <= 1'b0;
      ex_MemtoReg  <= 1'b0;
      ex_ReadData1 <= '0;
      ex_ReadData2 <= '0;
      ex_imm       <= '0;
      ex_funct     <= 6'd0;
      ex_Rs        <= 5'd0;
      ex_Rt        <= 5'd0;
      ex_Rd        <= 5'd0;
      ex_valid     <= 1'b0;
      bubble_cnt   <= '0;
    end else begin
      ex_valid    <= take;
      ex_RegWrite <= take & id_RegWrite;
      ex_ALUOp    <= take ? id_ALUOp : 2'b00;
      // RegDst/MemtoReg are X from the decoder when RegWrite=0
      ex_RegDst   <= take & id_RegWrite & id_RegDst;
      ex_MemtoReg <= take & id_RegWrite & id_MemtoReg;
      ex_ALUSrc   <= take & id_ALUSrc;
      ex_MemWrite <= take & id_MemWrite;
      ex_MemRead  <= take & id_MemRead;
      ex_ReadData1 <= id_ReadData1;
      ex_ReadData2 <= id_ReadData2;
      ex_imm   <= {{(DATA_W-16){id_imm16[15]}}, id_imm16};
      ex_funct <= id_funct;
      ex_Rs    <= id_Rs;
      ex_Rt    <= id_Rt;
      ex_Rd    <= id_Rd;
      if (cnt_inc)
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule
